// File: rtl/relu_grad_gate.sv
// ReLU gradient gate: records a per-lane "pre-activation was positive" mask on the
// forward pass and uses it, in FIFO order, to zero upstream gradient lanes on the backward pass.
module relu_grad_gate #(
  parameter int DATA_WIDTH = 8,
  parameter int SA_LENGTH  = 3,
  parameter int DEPTH      = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clear,
  input  logic                                  en,
  input  logic                                  fwd_valid,
  output logic                                  fwd_ready,
  input  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0]  fwd_in,
  input  logic                                  grad_valid,
  output logic                                  grad_ready,
  input  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0]  grad_in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [SA_LENGTH-1:0][DATA_WIDTH-1:0]  grad_out,
  output logic [$clog2(DEPTH):0]                count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [SA_LENGTH-1:0]                 mask_mem_q [DEPTH];
  logic [AW-1:0]                        wr_ptr_q, rd_ptr_q;
  logic [AW:0]                          count_q;
  logic                                 out_valid_q;
  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] grad_out_q;

  logic                                 fwd_xfer, grad_xfer;
  logic [SA_LENGTH-1:0]                 mask_d;
  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] grad_out_d;

  // Readies depend only on registered state, so a mask written this edge
  // cannot be consumed until the next cycle.
  assign fwd_ready  = (count_q != DEPTH_C);
  assign grad_ready = (count_q != '0) && (!out_valid_q || out_ready);
  assign fwd_xfer   = fwd_valid && fwd_ready;
  assign grad_xfer  = grad_valid && grad_ready;

  // Lanes are two's complement: positive means sign clear and nonzero.
  always_comb begin
    mask_d = '1;
    if (en) begin
      for (int i = 0; i < SA_LENGTH; i++) begin
        mask_d[i] = ~fwd_in[i][DATA_WIDTH-1] & (|fwd_in[i]);
      end
    end
  end

  always_comb begin
    grad_out_d = '0;
    for (int i = 0; i < SA_LENGTH; i++) begin
      grad_out_d[i] = mask_mem_q[rd_ptr_q][i] ? grad_in[i] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (fwd_xfer && !clear) begin
      mask_mem_q[wr_ptr_q] <= mask_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      grad_out_q  <= '0;
    end else if (clear) begin
      // grad_out intentionally keeps its last value across a flush
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (fwd_xfer) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (grad_xfer) begin
        rd_ptr_q    <= rd_ptr_q + AW'(1);
        grad_out_q  <= grad_out_d;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (fwd_xfer && !grad_xfer) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (!fwd_xfer && grad_xfer) begin
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign grad_out  = grad_out_q;
  assign count     = count_q;

endmodule

// File: tb/tb_relu_grad_gate.sv
// Bench for relu_grad_gate: directed scenarios plus randomized traffic against a
// queue-based reference model of the mask FIFO and output register.
module tb_relu_grad_gate;
  localparam int DW = 8;
  localparam int SA = 3;
  localparam int D  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0, en = 1'b0, fwd_valid = 1'b0, grad_valid = 1'b0, out_ready = 1'b0;
  logic [SA-1:0][DW-1:0] fwd_in = '0, grad_in = '0;
  logic fwd_ready, grad_ready, out_valid;
  logic [SA-1:0][DW-1:0] grad_out;
  logic [3:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit [SA-1:0]           mq[$];
  bit                    m_ov = 1'b0;
  logic [SA-1:0][DW-1:0] m_out = '0;

  relu_grad_gate #(.DATA_WIDTH(DW), .SA_LENGTH(SA), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(en),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_in(fwd_in),
    .grad_valid(grad_valid), .grad_ready(grad_ready), .grad_in(grad_in),
    .out_valid(out_valid), .out_ready(out_ready), .grad_out(grad_out), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [SA-1:0][DW-1:0] lanes(int a, int b, int c);
    logic [SA-1:0][DW-1:0] r;
    r[2] = a[DW-1:0];
    r[1] = b[DW-1:0];
    r[0] = c[DW-1:0];
    return r;
  endfunction

  // One clock: model decides transfers from pre-edge inputs, then advances.
  task automatic tick();
    bit m_fr, m_gr, fx, gx;
    bit [SA-1:0] new_mask, pm;
    m_fr = (mq.size() < D);
    m_gr = (mq.size() > 0) && (!m_ov || out_ready);
    fx = fwd_valid && m_fr;
    gx = grad_valid && m_gr;
    for (int i = 0; i < SA; i++) begin
      int v;
      v = $signed(fwd_in[i]);
      new_mask[i] = en ? (v > 0) : 1'b1;
    end
    @(posedge clk);
    #1;
    if (clear) begin
      mq.delete();
      m_ov = 1'b0;
    end else begin
      if (gx) begin
        pm = mq.pop_front();
        for (int i = 0; i < SA; i++) m_out[i] = pm[i] ? grad_in[i] : '0;
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (fx) mq.push_back(new_mask);
    end
  endtask

  task automatic idle();
    fwd_valid = 0; grad_valid = 0; clear = 0; out_ready = 1;
    tick();
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (grad_out !== '0) begin n_bad++; $display("FAIL reset_grad_out got=%h exp=0", grad_out); end
    n_cmp++; if (fwd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_fwd_ready got=%b exp=1", fwd_ready); end
    n_cmp++; if (grad_ready !== 1'b0) begin n_bad++; $display("FAIL reset_grad_ready got=%b exp=0", grad_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    en = 1; fwd_in = lanes(5, -100, 127); fwd_valid = 1;
    tick();
    fwd_valid = 0;
    n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL basic_count1 got=%0d exp=1", count); end
    grad_in = lanes(10, 20, -30); grad_valid = 1; out_ready = 1;
    tick();
    grad_valid = 0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
    n_cmp++; if (grad_out !== lanes(10, 0, -30)) begin n_bad++; $display("FAIL basic_grad_out got=%h exp=%h", grad_out, lanes(10, 0, -30)); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL basic_count0 got=%0d exp=0", count); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_out_drop got=%b exp=0", out_valid); end
  endtask

  task automatic test_passthru_and_edges();
    en = 0; fwd_in = lanes(-10, 15, 120); fwd_valid = 1;
    tick();
    en = 1; fwd_in = lanes(0, -128, 127);
    tick();
    fwd_valid = 0; grad_in = lanes(-1, -2, -3); grad_valid = 1; out_ready = 1;
    tick();
    n_cmp++; if (grad_out !== lanes(-1, -2, -3)) begin n_bad++; $display("FAIL passthru got=%h exp=%h", grad_out, lanes(-1, -2, -3)); end
    grad_in = lanes(7, 8, 9);
    tick();
    grad_valid = 0;
    n_cmp++; if (grad_out !== lanes(0, 0, 9)) begin n_bad++; $display("FAIL edge_values got=%h exp=%h", grad_out, lanes(0, 0, 9)); end
    idle();
  endtask

  task automatic test_full();
    en = 1; fwd_valid = 1; out_ready = 1;
    for (int k = 0; k < D; k++) begin
      fwd_in = {$urandom, $urandom, $urandom};
      tick();
    end
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL full_count got=%0d exp=8", count); end
    n_cmp++; if (fwd_ready !== 1'b0) begin n_bad++; $display("FAIL full_fwd_ready got=%b exp=0", fwd_ready); end
    tick();
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL full_ninth_rejected got=%0d exp=8", count); end
    fwd_valid = 0; grad_valid = 1; grad_in = {$urandom, $urandom, $urandom};
    tick();
    n_cmp++; if (fwd_ready !== 1'b1) begin n_bad++; $display("FAIL full_after_pop_ready got=%b exp=1", fwd_ready); end
    n_cmp++; if (count !== 4'd7) begin n_bad++; $display("FAIL full_after_pop_count got=%0d exp=7", count); end
    n_cmp++; if (grad_out !== m_out) begin n_bad++; $display("FAIL full_first_out got=%h exp=%h", grad_out, m_out); end
    for (int k = 0; k < 20 && mq.size() > 0; k++) begin
      grad_in = {$urandom, $urandom, $urandom};
      tick();
      n_cmp++; if (grad_out !== m_out) begin n_bad++; $display("FAIL full_drain_out got=%h exp=%h", grad_out, m_out); end
    end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL full_drained got=%0d exp=0", count); end
    grad_valid = 0;
    idle();
  endtask

  task automatic test_order_wrap();
    logic [SA-1:0][DW-1:0] pats [3];
    pats[0] = lanes(1, -1, 1);
    pats[1] = lanes(-1, 1, -1);
    pats[2] = lanes(0, 0, 100);
    for (int r = 0; r < 4; r++) begin
      en = 1; fwd_valid = 1; grad_valid = 0; out_ready = 1;
      for (int k = 0; k < 3; k++) begin
        fwd_in = pats[k];
        tick();
      end
      fwd_valid = 0; grad_valid = 1;
      for (int k = 0; k < 3; k++) begin
        grad_in = lanes(11 + k, 22 + k, 33 + k);
        tick();
        n_cmp++; if (grad_out !== m_out) begin n_bad++; $display("FAIL order_r%0d_b%0d got=%h exp=%h", r, k, grad_out, m_out); end
      end
    end
    grad_valid = 0;
    idle();
  endtask

  task automatic test_backpressure();
    logic [SA-1:0][DW-1:0] held;
    en = 1; fwd_valid = 1; fwd_in = lanes(3, -3, 3);
    tick();
    fwd_in = lanes(-3, 3, -3);
    tick();
    fwd_valid = 0; grad_valid = 1; out_ready = 0; grad_in = lanes(40, 50, 60);
    tick();
    held = lanes(40, 0, 60);
    grad_in = lanes(-7, -8, -9);
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if (grad_ready !== 1'b0) begin n_bad++; $display("FAIL bp_grad_ready c%0d got=%b exp=0", k, grad_ready); end
      n_cmp++; if (out_valid !== 1'b1 || grad_out !== held) begin n_bad++; $display("FAIL bp_hold c%0d got=%b/%h exp=1/%h", k, out_valid, grad_out, held); end
    end
    out_ready = 1;
    #1;
    n_cmp++; if (grad_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got=%b exp=1", grad_ready); end
    tick();
    n_cmp++; if (grad_out !== lanes(0, -8, 0) || out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_next_beat got=%b/%h exp=1/%h", out_valid, grad_out, lanes(0, -8, 0)); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL bp_count got=%0d exp=0", count); end
    grad_valid = 0;
    idle();
  endtask

  task automatic test_clear();
    en = 1; fwd_valid = 1;
    for (int k = 0; k < 3; k++) begin
      fwd_in = {$urandom, $urandom, $urandom};
      tick();
    end
    grad_valid = 1; grad_in = lanes(1, 2, 3); out_ready = 0;
    tick();
    // flush with both transfers requested: everything discarded
    clear = 1;
    tick();
    clear = 0; fwd_valid = 0; grad_valid = 0;
    #1;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL clear_count got=%0d exp=0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clear_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (grad_ready !== 1'b0) begin n_bad++; $display("FAIL clear_grad_ready got=%b exp=0", grad_ready); end
    n_cmp++; if (fwd_ready !== 1'b1) begin n_bad++; $display("FAIL clear_fwd_ready got=%b exp=1", fwd_ready); end
    n_cmp++; if (grad_out !== m_out) begin n_bad++; $display("FAIL clear_grad_out_hold got=%h exp=%h", grad_out, m_out); end
    idle();
  endtask

  task automatic test_async_reset();
    en = 1; fwd_valid = 1;
    for (int k = 0; k < 3; k++) begin
      fwd_in = {$urandom, $urandom, $urandom};
      tick();
    end
    fwd_valid = 0; grad_valid = 1; grad_in = lanes(5, 6, 7); out_ready = 0;
    tick();
    grad_valid = 0;
    #2 rst_n = 0;
    #1;
    mq.delete(); m_ov = 0; m_out = '0;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL arst_count got=%0d exp=0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (grad_out !== '0) begin n_bad++; $display("FAIL arst_grad_out got=%h exp=0", grad_out); end
    n_cmp++; if (fwd_ready !== 1'b1 || grad_ready !== 1'b0) begin n_bad++; $display("FAIL arst_ready got=%b%b exp=10", fwd_ready, grad_ready); end
    @(posedge clk); #1;
    rst_n = 1;
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      en = ($urandom_range(3) != 0);
      fwd_valid = $urandom_range(1);
      grad_valid = $urandom_range(1);
      out_ready = ($urandom_range(3) != 0);
      clear = ($urandom_range(40) == 0);
      fwd_in = {$urandom, $urandom, $urandom};
      grad_in = {$urandom, $urandom, $urandom};
      tick();
      n_cmp++;
      if (count !== 4'(mq.size()) || out_valid !== m_ov || grad_out !== m_out ||
          fwd_ready !== (mq.size() < D) || grad_ready !== ((mq.size() > 0) && (!m_ov || out_ready))) begin
        n_bad++;
        $display("FAIL random c%0d got cnt=%0d ov=%b out=%h fr=%b gr=%b exp cnt=%0d ov=%b out=%h",
                 c, count, out_valid, grad_out, fwd_ready, grad_ready, mq.size(), m_ov, m_out);
      end
    end
    clear = 0;
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_passthru_and_edges();
    test_full();
    test_order_wrap();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/relu_grad_gate.md
RELU_GRAD_GATE -- requirements
Module: relu_grad_gate

Interface
REQ-001 Parameter DATA_WIDTH, default 8; signed width of each activation and gradient lane.
REQ-002 Parameter SA_LENGTH, default 3; number of lanes, one per systolic-array column.
REQ-003 Parameter DEPTH, default 8; mask buffer entries, power of two, >= 2.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 clear  input  1  synchronous flush of the mask buffer and output stage.
REQ-007 en  input  1  activation enable, sampled with each forward beat; 0 means the layer has no ReLU.
REQ-008 fwd_valid  input  1  forward pre-activation beat valid.
REQ-009 fwd_ready  output  1  mask buffer can accept a forward beat.
REQ-010 fwd_in  input  SA_LENGTH x DATA_WIDTH signed  forward pre-activation lanes.
REQ-011 grad_valid  input  1  incoming upstream gradient beat valid.
REQ-012 grad_ready  output  1  gradient beat accepted this cycle.
REQ-013 grad_in  input  SA_LENGTH x DATA_WIDTH signed  upstream gradient lanes.
REQ-014 out_valid  output  1  gated gradient beat valid.
REQ-015 out_ready  input  1  downstream accepts the gated beat.
REQ-016 grad_out  output  SA_LENGTH x DATA_WIDTH signed  gated gradient lanes, registered.
REQ-017 count  output  $clog2(DEPTH)+1  number of stored mask entries.

Function
REQ-018 Forward transfer occurs when fwd_valid and fwd_ready are both 1 on a rising edge.
REQ-019 On a forward transfer, store one SA_LENGTH-bit mask: lane bit = (fwd_in[i] > 0) when en=1; all ones when en=0.
REQ-020 Zero input yields mask bit 0; most-negative value yields 0; maximum positive value yields 1.
REQ-021 Mask buffer is FIFO-ordered: masks are consumed in the order they were written.
REQ-022 fwd_ready = (count < DEPTH); combinational from registered state only.
REQ-023 grad_ready = (count > 0) and (out_valid = 0 or out_ready = 1); no same-cycle bypass from forward to gradient side.
REQ-024 Gradient transfer occurs when grad_valid and grad_ready are both 1; it pops one mask.
REQ-025 On a gradient transfer, grad_out[i] <= mask[i] ? grad_in[i] : 0 and out_valid <= 1 on the same edge; latency one cycle.
REQ-026 out_valid clears on an edge where out_valid=1, out_ready=1 and no gradient transfer occurs.
REQ-027 While out_valid=1 and out_ready=0, grad_out and out_valid hold stable.
REQ-028 Simultaneous forward and gradient transfer: count unchanged, both pointers advance.
REQ-029 Read and write pointers wrap modulo DEPTH; count saturates at neither end because ready signals block over/underflow.
REQ-030 clear=1 has priority over all transfers: count <= 0, pointers <= 0, out_valid <= 0; grad_out holds its value; fwd_ready and grad_ready still reflect pre-clear state that cycle but the transfers are discarded.
REQ-031 No arithmetic on gradients; lanes pass bit-exact or are zeroed; no saturation or rounding.

Reset
REQ-032 rst_n=0 asynchronously forces count=0, pointers=0, out_valid=0, grad_out all lanes 0.
REQ-033 Immediately after reset: fwd_ready=1, grad_ready=0.
REQ-034 Reset asserted mid-operation discards all stored masks and any pending output beat.

Verification
REQ-035 Forward en=1, fwd_in={5,-100,127}; then grad_in={10,20,-30}, out_ready=1 -> next cycle out_valid=1, grad_out={10,0,-30}, count back to 0.
REQ-036 Forward en=0, fwd_in={-10,15,120}; grad_in={-1,-2,-3} -> grad_out={-1,-2,-3}.
REQ-037 Fill DEPTH=8 forward beats -> fwd_ready=0, count=8; ninth fwd_valid is not accepted; one gradient pop -> fwd_ready=1.
REQ-038 Masks written for beats A,B,C with distinct patterns; three gradient beats -> outputs gated by A,B,C in order, including across pointer wrap after 10+ pushes/pops.
REQ-039 out_ready=0 with out_valid=1 -> grad_ready=0, grad_out stable for 5 cycles; out_ready=1 -> pending beat consumed and next beat accepted that edge.
REQ-040 Push 3 masks, assert clear (and separately rst_n=0 asynchronously) -> count=0, out_valid=0, grad_ready=0, fwd_ready=1.
